custom_axi_result_fifo: RTL and testbench
=========================================

# custom_axi_result_fifo

Downstream capture stage for the `custom_axi_ip` datapath. It samples each completed result that the IP presents on its 33-bit `{data, flag}` output with `enable_out[0]`. Each result is tagged with a sequence number and buffered in a small FIFO. Results are offered to a register-read or AXI read-channel consumer through a valid/ready handshake. Drops, malformed results and occupancy are reported as status for software.

## Interface
- `DATA_WIDTH`, 32, width of the result payload (the IP output minus its flag bit).
- `DEPTH`, 4, FIFO entries; must be a power of two, at least 2.
- `clk_i` in 1: the single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `res_data_i` in DATA_WIDTH+1: result bus from the IP; [DATA_WIDTH:1] is payload, [0] is the done flag.
- `res_en_i` in 2: result enable from the IP; bit 0 qualifies a result; bit 1 is ignored.
- `clear_i` in 1: synchronous soft clear from software.
- `m_data_o` out DATA_WIDTH: payload at the FIFO head.
- `m_seq_o` out 8: sequence tag at the FIFO head.
- `m_valid_o` out 1: head entry is valid.
- `m_ready_i` in 1: consumer accepts the head entry.
- `level_o` out $clog2(DEPTH+1): current number of stored entries.
- `overflow_o` out 1: sticky; at least one result was dropped because the FIFO was full.
- `malformed_o` out 1: sticky; `res_en_i[0]` was seen with `res_data_i[0]`=0.
- `drop_cnt_o` out 8: count of dropped results, saturating at 255.

## Operation
- **Capture event.** A capture event is a cycle with `res_en_i[0]`=1 and `res_data_i[0]`=1.
  - If `res_en_i[0]`=1 and `res_data_i[0]`=0, the cycle is not a capture.
  - Instead, `malformed_o` is set and nothing else changes.
- **Sequence counter.** An internal 8-bit counter `seq` increments on every capture event, whether the result is accepted or dropped.
  - It wraps 255→0.
  - The entry stores the `seq` value held before the increment, so the first capture after reset carries tag 0.
  - Gaps in `m_seq_o` therefore expose drops to the reader.
- **Pop.** A pop occurs when `m_valid_o`=1 and `m_ready_i`=1.
- **Push acceptance.** A capture event is accepted when `level_o` < DEPTH, or when `level_o` = DEPTH and a pop occurs in the same cycle.
  - On acceptance, `{payload, seq}` is written at the write pointer.
- **Drop.** A capture event when the FIFO is full and no pop occurs is dropped:
  - `overflow_o` is set;
  - `drop_cnt_o` increments, holding at 255;
  - `seq` still increments.
- **Level update.** `level_o` changes by +1 on push only, −1 on pop only, and 0 on simultaneous push and pop.
- **Pointers.** The write and read pointers are $clog2(DEPTH) bits and wrap naturally.
- **Head outputs.** `m_valid_o` = (`level_o` != 0). `m_data_o` and `m_seq_o` are the stored entry at the read pointer.
  - When `m_valid_o`=0 their values are don't-care, but they must not be X after reset.
- **Stalled head.** When `m_valid_o`=1 and `m_ready_i`=0, the head outputs hold stable until a pop.
- **Soft clear.** `clear_i` takes priority over capture and pop in the same cycle:
  - it empties the FIFO (pointers and `level_o` go to 0);
  - it clears `overflow_o`, `malformed_o` and `drop_cnt_o`;
  - it resets `seq` to 0.
  - Any capture or pop in that cycle is discarded.
- **Reset.** `rst_i` has the same effect as `clear_i`. Storage contents are zeroed.
  - Reset values: `m_data_o`=0, `m_seq_o`=0, `m_valid_o`=0, `level_o`=0, `overflow_o`=0, `malformed_o`=0, `drop_cnt_o`=0.
- **Mid-operation reset.** Reset asserted while entries are pending discards them; no pop is reported.

## Timing
- **Capture-to-head latency.** A capture accepted in cycle N is visible at the head (`m_valid_o`=1 if the FIFO was empty) in cycle N+1.
  - There is no combinational bypass from `res_data_i` to `m_data_o`.
- **Pop latency.** A pop in cycle N presents the next entry, or deasserts `m_valid_o`, in cycle N+1.
- **Back-to-back traffic.** One capture and one pop per cycle are sustainable indefinitely with no drops once `level_o` ≥ 1.
- **Status outputs.** `level_o`, `overflow_o`, `malformed_o` and `drop_cnt_o` are registered and update in the cycle after the causing event.
- **Source rate.** The IP produces a result at most once every 3 cycles (IDLE→BUSY→DONE). The FIFO must nonetheless accept a capture on every cycle.
- **Inputs.** All inputs are sampled on the rising edge of `clk_i`.

## Test plan
- **Basic capture.** After reset, capture `res_data_i`={32'h0000_0005,1'b1} with `res_en_i`=2'b01, `m_ready_i`=0.
  - Next cycle: `m_valid_o`=1, `m_data_o`=32'h5, `m_seq_o`=0, `level_o`=1.
- **Fill and overflow.** With `m_ready_i`=0, make 6 captures of data 1..6 at DEPTH=4.
  - `level_o`=4, `overflow_o`=1, `drop_cnt_o`=2.
  - Draining yields data 1,2,3,4 with seq 0,1,2,3.
  - A following capture of data 7 carries seq 6.
- **Push and pop when full.** With the FIFO full, capture data 9 and assert `m_ready_i`=1 in the same cycle.
  - Data 9 is accepted, `level_o` stays 4, `overflow_o` unchanged, and the head advances.
- **Malformed result.** Drive `res_en_i`=2'b01 with `res_data_i`[0]=0.
  - `malformed_o`=1, `level_o` unchanged, and the next valid capture still gets the next seq.
- **Clear priority.** Assert `clear_i` with a capture and a pop in the same cycle while `level_o`=3 and `drop_cnt_o`=5.
  - Next cycle: `level_o`=0, `m_valid_o`=0, `drop_cnt_o`=0, and the following capture has seq 0.
- **Wrap and saturation.** Make 300 captures with `m_ready_i`=0 at DEPTH=4.
  - `drop_cnt_o`=255 (saturated).
  - After draining, a subsequent accepted capture shows seq 300 mod 256 = 44.

Source files
------------

// File: rtl/custom_axi_result_fifo.sv
// custom_axi_result_fifo: captures completed results from custom_axi_ip, tags each
// with a sequence number, buffers them in a small FIFO and reports drop/malformed status.
module custom_axi_result_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [DATA_WIDTH:0]            res_data_i,
    input  logic [1:0]                     res_en_i,
    input  logic                           clear_i,
    output logic [DATA_WIDTH-1:0]          m_data_o,
    output logic [7:0]                     m_seq_o,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]     level_o,
    output logic                           overflow_o,
    output logic                           malformed_o,
    output logic [7:0]                     drop_cnt_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned SEQ_W = 8;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [SEQ_W-1:0]      seq;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [SEQ_W-1:0]   r_seq;
    logic               r_overflow;
    logic               r_malformed;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_capture;
    logic               w_malformed;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_unused;

    // Event decode: capture needs enable plus done flag; full FIFO may still accept if popping.
    assign w_capture   = res_en_i[0] & res_data_i[0];
    assign w_malformed = res_en_i[0] & ~res_data_i[0];
    assign w_full      = (r_level == LVL_W'(DEPTH));
    assign w_pop       = (r_level != '0) & m_ready_i;
    assign w_push      = w_capture & (~w_full | w_pop);
    assign w_drop      = w_capture & w_full & ~w_pop;
    assign w_unused    = res_en_i[1];

    // Pointer and occupancy tracking; clear discards any same-cycle push or pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Entry storage: zeroed on reset so head outputs are never X; written on accepted capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (!clear_i && w_push) begin
            r_mem[r_wr_ptr] <= '{data: res_data_i[DATA_WIDTH:1], seq: r_seq};
        end
    end

    // Sequence tag and sticky status; seq advances on every capture, accepted or dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_seq       <= '0;
            r_overflow  <= 1'b0;
            r_malformed <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_capture) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
            if (w_malformed) begin
                r_malformed <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {CNT_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Head and status outputs are straight reads of registered state.
    assign m_data_o    = r_mem[r_rd_ptr].data;
    assign m_seq_o     = r_mem[r_rd_ptr].seq;
    assign m_valid_o   = (r_level != '0);
    assign level_o     = r_level;
    assign overflow_o  = r_overflow;
    assign malformed_o = r_malformed;
    assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_custom_axi_result_fifo.sv
// Self-checking bench for custom_axi_result_fifo: directed test-plan steps plus
// randomized traffic, all compared against a queue-based reference model.
module tb_custom_axi_result_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic                       clk_i = 1'b0;
    logic                       rst_i = 1'b1;
    logic [DW:0]                res_data_i = '0;
    logic [1:0]                 res_en_i = '0;
    logic                       clear_i = 1'b0;
    logic [DW-1:0]              m_data_o;
    logic [7:0]                 m_seq_o;
    logic                       m_valid_o;
    logic                       m_ready_i = 1'b0;
    logic [$clog2(DEPTH+1)-1:0] level_o;
    logic                       overflow_o;
    logic                       malformed_o;
    logic [7:0]                 drop_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [39:0] q[$];
    int          m_seq = 0;
    bit          m_ovf = 0;
    bit          m_mal = 0;
    int          m_drop = 0;

    custom_axi_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .res_data_i  (res_data_i),
        .res_en_i    (res_en_i),
        .clear_i     (clear_i),
        .m_data_o    (m_data_o),
        .m_seq_o     (m_seq_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .level_o     (level_o),
        .overflow_o  (overflow_o),
        .malformed_o (malformed_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 64'(level_o), 64'(q.size()));
        chk({tag, ".valid"}, 64'(m_valid_o), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".data"}, 64'(m_data_o), 64'(q[0][39:8]));
            chk({tag, ".seq"},  64'(m_seq_o),  64'(q[0][7:0]));
        end else begin
            chk({tag, ".head_known"}, 64'($isunknown({m_data_o, m_seq_o})), 64'(0));
        end
        chk({tag, ".overflow"},  64'(overflow_o),  64'(m_ovf));
        chk({tag, ".malformed"}, 64'(malformed_o), 64'(m_mal));
        chk({tag, ".drop_cnt"},  64'(drop_cnt_o),  64'(m_drop));
    endtask

    // One clock: drive inputs, advance model by the spec rules, compare.
    task automatic step(input string tag, input bit en0, input bit flag, input logic [31:0] d,
                        input bit rdy, input bit clr, input bit rst, input bit en1 = 1'b0);
        bit pop, cap, full;
        rst_i      = rst;
        clear_i    = clr;
        res_en_i   = {en1, en0};
        res_data_i = {d, flag};
        m_ready_i  = rdy;
        @(posedge clk_i);
        #1;
        if (rst || clr) begin
            q.delete();
            m_seq  = 0;
            m_ovf  = 0;
            m_mal  = 0;
            m_drop = 0;
        end else begin
            pop  = (q.size() != 0) && rdy;
            cap  = en0 && flag;
            full = (q.size() == DEPTH);
            if (en0 && !flag) m_mal = 1;
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (!full || pop) begin
                    q.push_back({d, 8'(m_seq)});
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
                m_seq = (m_seq + 1) % 256;
            end
        end
        rst_i    = 1'b0;
        clear_i  = 1'b0;
        res_en_i = '0;
        check_all(tag);
    endtask

    initial begin
        // Reset
        step("reset", 0, 0, 0, 0, 0, 1);
        step("reset", 0, 0, 0, 0, 0, 1);
        chk("reset.m_data", 64'(m_data_o), 64'(0));
        chk("reset.m_seq",  64'(m_seq_o),  64'(0));

        // Basic capture
        step("basic", 1, 1, 32'h5, 0, 0, 0);
        chk("basic.data_const", 64'(m_data_o), 64'h5);
        chk("basic.seq_const",  64'(m_seq_o),  64'h0);
        chk("basic.level_const", 64'(level_o), 64'd1);

        // Fill and overflow
        step("clr1", 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 6; i++) step("fill", 1, 1, 32'(i), 0, 0, 0);
        chk("fill.level_const", 64'(level_o), 64'd4);
        chk("fill.ovf_const",   64'(overflow_o), 64'd1);
        chk("fill.drop_const",  64'(drop_cnt_o), 64'd2);
        for (int i = 0; i < 4; i++) step("drain", 0, 0, 0, 1, 0, 0);
        step("cap7", 1, 1, 32'h7, 0, 0, 0);
        chk("cap7.seq_const", 64'(m_seq_o), 64'd6);

        // Push and pop when full
        for (int i = 0; i < 3; i++) step("refill", 1, 1, 32'(8'h70 + i), 0, 0, 0);
        step("full_pushpop", 1, 1, 32'h9, 1, 0, 0);
        chk("full_pushpop.level_const", 64'(level_o), 64'd4);
        for (int i = 0; i < 4; i++) step("drain2", 0, 0, 0, 1, 0, 0);

        // Malformed result, also with ignored en[1]
        step("malformed", 1, 0, 32'hDEAD, 0, 0, 0);
        chk("malformed.const", 64'(malformed_o), 64'd1);
        step("en1_only", 0, 1, 32'hBEEF, 0, 0, 0, 1'b1);
        step("after_mal", 1, 1, 32'h11, 0, 0, 0);

        // Clear priority with level 3, drop_cnt 5
        step("clr2", 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) step("prep", 1, 1, 32'(i + 32'h100), 0, 0, 0);
        step("prep_pop", 0, 0, 0, 1, 0, 0);
        chk("prep.level_const", 64'(level_o), 64'd3);
        chk("prep.drop_const",  64'(drop_cnt_o), 64'd5);
        step("clr_prio", 1, 1, 32'h55, 1, 1, 0);
        chk("clr_prio.level_const", 64'(level_o), 64'd0);
        step("post_clr", 1, 1, 32'h66, 0, 0, 0);
        chk("post_clr.seq_const", 64'(m_seq_o), 64'd0);

        // Wrap and saturation
        step("clr3", 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 300; i++) step("wrap", 1, 1, $urandom, 0, 0, 0);
        chk("wrap.drop_const", 64'(drop_cnt_o), 64'd255);
        for (int i = 0; i < 4; i++) step("drain3", 0, 0, 0, 1, 0, 0);
        step("wrap_cap", 1, 1, 32'hABC, 0, 0, 0);
        chk("wrap_cap.seq_const", 64'(m_seq_o), 64'd44);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0), $urandom,
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 49) == 0), 0,
                 ($urandom_range(0, 1) == 1));
        end

        // Mid-operation reset discards pending entries
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 1, 32'(i + 32'hC0), 0, 0, 0);
        step("mid_rst", 1, 1, 32'hEE, 1, 0, 1);
        chk("mid_rst.valid_const", 64'(m_valid_o), 64'd0);
        step("post_rst", 1, 1, 32'hF0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
